// File: rtl/cpu_datapath_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_datapath_pkg
//  Description : Shared constants for the single-bus CPU datapath: word width,
//                one-hot ALU op indices and bus-source priority indices
//                (lower index = higher priority on the bus).
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_datapath_pkg;

  localparam int CPU_WIDTH = 32;

  // ALU op strobe indices, in port order (index 0 has highest priority)
  localparam int NUM_OPS  = 13;
  localparam int OP_AND   = 0;
  localparam int OP_OR    = 1;
  localparam int OP_ADD   = 2;
  localparam int OP_SUB   = 3;
  localparam int OP_MUL   = 4;
  localparam int OP_DIV   = 5;
  localparam int OP_SHR   = 6;
  localparam int OP_SHRA  = 7;
  localparam int OP_SHL   = 8;
  localparam int OP_ROR   = 9;
  localparam int OP_ROL   = 10;
  localparam int OP_NEG   = 11;
  localparam int OP_NOT   = 12;

  // Bus source indices; when several out-strobes are high the lowest wins
  localparam int NUM_SEL  = 27;
  localparam int SEL_R0   = 0;   // R0..R15 occupy 0..15
  localparam int SEL_HI   = 16;
  localparam int SEL_LO   = 17;
  localparam int SEL_ZHI  = 18;
  localparam int SEL_ZLO  = 19;
  localparam int SEL_PC   = 20;
  localparam int SEL_MDR  = 21;
  localparam int SEL_IN   = 22;
  localparam int SEL_C    = 23;
  localparam int SEL_Y    = 24;
  localparam int SEL_MAR  = 25;
  localparam int SEL_IR   = 26;

  typedef logic [NUM_OPS-1:0] alu_op_t;

endpackage
`default_nettype wire

// File: rtl/cpu_datapath_alu.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_alu
//  Description : Combinational ALU. A comes from Y, B from the bus; the
//                double-width result feeds the Z register.
//  Ports       : y_i      [WIDTH]    operand A
//                b_i      [WIDTH]    operand B
//                op_i     [NUM_OPS]  one-hot op strobes (lowest index wins)
//                result_o [2*WIDTH]  {Zhigh, Zlow}
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_alu
  import cpu_datapath_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH
) (
  input  logic [WIDTH-1:0]   y_i,
  input  logic [WIDTH-1:0]   b_i,
  input  alu_op_t            op_i,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int SHW = $clog2(WIDTH);

  logic signed [WIDTH-1:0]   ys;
  logic signed [WIDTH-1:0]   bs;
  logic signed [2*WIDTH-1:0] ye;
  logic signed [2*WIDTH-1:0] be;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]   quot;
  logic signed [WIDTH-1:0]   rem;
  logic signed [WIDTH-1:0]   sra;
  logic        [SHW-1:0]     sh;
  logic        [SHW-1:0]     nsh;

  assign ys   = y_i;
  assign bs   = b_i;
  assign ye   = {{WIDTH{y_i[WIDTH-1]}}, y_i};
  assign be   = {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign prod = ye * be;
  assign sh   = b_i[SHW-1:0];
  // Complementary shift for rotates; sh=0 gives nsh=0 so the OR collapses to Y
  assign nsh  = -sh;
  assign sra  = ys >>> sh;

  // Both operands are signed, so / truncates toward zero and % follows the
  // dividend's sign; the zero-divisor case is forced to 0 explicitly.
  always_comb begin
    quot = '0;
    rem  = '0;
    if (b_i != '0) begin
      quot = ys / bs;
      rem  = ys % bs;
    end
  end

  always_comb begin
    result_o = '0;
    if      (op_i[OP_AND])  result_o = {{WIDTH{1'b0}}, y_i & b_i};
    else if (op_i[OP_OR])   result_o = {{WIDTH{1'b0}}, y_i | b_i};
    else if (op_i[OP_ADD])  result_o = {{WIDTH{1'b0}}, y_i + b_i};
    else if (op_i[OP_SUB])  result_o = {{WIDTH{1'b0}}, y_i - b_i};
    else if (op_i[OP_MUL])  result_o = prod;
    else if (op_i[OP_DIV])  result_o = {rem, quot};
    else if (op_i[OP_SHR])  result_o = {{WIDTH{1'b0}}, y_i >> sh};
    else if (op_i[OP_SHRA]) result_o = {{WIDTH{1'b0}}, sra};
    else if (op_i[OP_SHL])  result_o = {{WIDTH{1'b0}}, y_i << sh};
    else if (op_i[OP_ROR])  result_o = {{WIDTH{1'b0}}, (y_i >> sh) | (y_i << nsh)};
    else if (op_i[OP_ROL])  result_o = {{WIDTH{1'b0}}, (y_i << sh) | (y_i >> nsh)};
    else if (op_i[OP_NEG])  result_o = {{WIDTH{1'b0}}, -b_i};
    else if (op_i[OP_NOT])  result_o = {{WIDTH{1'b0}}, ~b_i};
  end

endmodule
`default_nettype wire

// File: rtl/cpu_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_datapath
//  Description : 32-bit single-bus CPU datapath. R0-R15, HI, LO, PC, IR, Y,
//                64-bit Z, MAR and MDR share one combinational priority bus.
//                Every strobe is driven externally; there is no sequencer.
//  Ports       : clk, reset (async, active low)
//                R*out/HIout/.../IRout  bus source selects
//                R*in/HIin/.../MDRin    register load enables
//                Read   MDR source (1=IN, 0=bus)   IncPC  PC+1 with PCin
//                AND..NOT               one-hot ALU op strobes
//                IN     memory / input-port word
//                BusMuxOut  current bus value     PC  program counter
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_datapath
  import cpu_datapath_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             R0out,  R1out,  R2out,  R3out,
  input  logic             R4out,  R5out,  R6out,  R7out,
  input  logic             R8out,  R9out,  R10out, R11out,
  input  logic             R12out, R13out, R14out, R15out,
  input  logic             HIout,  LOout,  Zhighout, Zlowout,
  input  logic             PCout,  IRout,  MDRout, INout,
  input  logic             Cout,   Yout,   MARout,
  input  logic             Read,
  input  logic             IncPC,
  input  logic             AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA,
  input  logic             SHL, ROR, ROL, NEG, NOT,
  input  logic             R0in,  R1in,  R2in,  R3in,
  input  logic             R4in,  R5in,  R6in,  R7in,
  input  logic             R8in,  R9in,  R10in, R11in,
  input  logic             R12in, R13in, R14in, R15in,
  input  logic             HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] BusMuxOut,
  output logic [WIDTH-1:0] PC
);

  logic [NUM_SEL-1:0]   sel;
  logic [15:0]          gpr_en;
  alu_op_t              ops;
  logic [WIDTH-1:0]     src [NUM_SEL];
  logic [WIDTH-1:0]     bus;
  logic [WIDTH-1:0]     c_ext;
  logic [2*WIDTH-1:0]   alu_res;

  logic [WIDTH-1:0]     gpr_q [16];
  logic [WIDTH-1:0]     hi_q, lo_q, pc_q, ir_q, y_q, mar_q, mdr_q;
  logic [2*WIDTH-1:0]   z_q;
  logic [WIDTH-1:0]     pc_d, mdr_d;

  assign sel = {IRout, MARout, Yout, Cout, INout, MDRout, PCout, Zlowout,
                Zhighout, LOout, HIout,
                R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

  assign gpr_en = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

  assign ops = {NOT, NEG, ROL, ROR, SHL, SHRA, SHR, DIV, MUL, SUB, ADD, OR, AND};

  // Immediate field IR[18:0], sign-extended
  assign c_ext = {{(WIDTH-19){ir_q[18]}}, ir_q[18:0]};

  // ---------------------------------------------------------------- bus mux
  generate
    for (genvar g = 0; g < 16; g++) begin : g_gpr_src
      assign src[SEL_R0+g] = gpr_q[g];
    end
  endgenerate

  assign src[SEL_HI]  = hi_q;
  assign src[SEL_LO]  = lo_q;
  assign src[SEL_ZHI] = z_q[2*WIDTH-1:WIDTH];
  assign src[SEL_ZLO] = z_q[WIDTH-1:0];
  assign src[SEL_PC]  = pc_q;
  assign src[SEL_MDR] = mdr_q;
  assign src[SEL_IN]  = IN;
  assign src[SEL_C]   = c_ext;
  assign src[SEL_Y]   = y_q;
  assign src[SEL_MAR] = mar_q;
  assign src[SEL_IR]  = ir_q;

  // Scan from lowest priority upward so the lowest asserted index is the last
  // assignment and therefore wins.
  always_comb begin
    bus = '0;
    for (int i = NUM_SEL - 1; i >= 0; i--) begin
      if (sel[i]) bus = src[i];
    end
  end

  assign BusMuxOut = bus;
  assign PC        = pc_q;

  // -------------------------------------------------------------------- ALU
  cpu_alu #(
    .WIDTH    (WIDTH)
  ) u_alu (
    .y_i      (y_q),
    .b_i      (bus),
    .op_i     (ops),
    .result_o (alu_res)
  );

  // -------------------------------------------------------------- registers
  assign pc_d  = IncPC ? pc_q + WIDTH'(1) : bus;
  assign mdr_d = Read  ? IN               : bus;

  generate
    for (genvar g = 0; g < 16; g++) begin : g_gpr
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)         gpr_q[g] <= '0;
        else if (gpr_en[g]) gpr_q[g] <= bus;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      y_q   <= '0;
      z_q   <= '0;
      mar_q <= '0;
      mdr_q <= '0;
    end else begin
      if (HIin)  hi_q  <= bus;
      if (LOin)  lo_q  <= bus;
      if (PCin)  pc_q  <= pc_d;
      if (IRin)  ir_q  <= bus;
      if (Yin)   y_q   <= bus;
      if (Zin)   z_q   <= alu_res;
      if (MARin) mar_q <= bus;
      if (MDRin) mdr_q <= mdr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_datapath
//  Description : Directed self-checking bench for cpu_datapath.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_datapath;

  // source select indices (bench-local)
  localparam int S_HI = 16, S_LO = 17, S_ZH = 18, S_ZL = 19, S_PC = 20;
  localparam int S_MDR = 21, S_IN = 22, S_C = 23, S_Y = 24, S_MAR = 25, S_IR = 26;
  // load enable indices
  localparam int E_HI = 16, E_LO = 17, E_PC = 18, E_IR = 19, E_Z = 20;
  localparam int E_Y = 21, E_MAR = 22, E_MDR = 23;
  // op indices
  localparam int O_AND = 0, O_OR = 1, O_ADD = 2, O_SUB = 3, O_MUL = 4, O_DIV = 5;
  localparam int O_SHR = 6, O_SHRA = 7, O_SHL = 8, O_ROR = 9, O_ROL = 10;
  localparam int O_NEG = 11, O_NOT = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        Read, IncPC;
  logic [26:0] sel;
  logic [23:0] en;
  logic [12:0] op;
  logic [31:0] in_w;
  wire  [31:0] bus;
  wire  [31:0] pc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_datapath #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .R0out(sel[0]),   .R1out(sel[1]),   .R2out(sel[2]),   .R3out(sel[3]),
    .R4out(sel[4]),   .R5out(sel[5]),   .R6out(sel[6]),   .R7out(sel[7]),
    .R8out(sel[8]),   .R9out(sel[9]),   .R10out(sel[10]), .R11out(sel[11]),
    .R12out(sel[12]), .R13out(sel[13]), .R14out(sel[14]), .R15out(sel[15]),
    .HIout(sel[S_HI]), .LOout(sel[S_LO]), .Zhighout(sel[S_ZH]), .Zlowout(sel[S_ZL]),
    .PCout(sel[S_PC]), .IRout(sel[S_IR]), .MDRout(sel[S_MDR]), .INout(sel[S_IN]),
    .Cout(sel[S_C]), .Yout(sel[S_Y]), .MARout(sel[S_MAR]),
    .Read(Read), .IncPC(IncPC),
    .AND(op[O_AND]), .OR(op[O_OR]), .ADD(op[O_ADD]), .SUB(op[O_SUB]),
    .MUL(op[O_MUL]), .DIV(op[O_DIV]), .SHR(op[O_SHR]), .SHRA(op[O_SHRA]),
    .SHL(op[O_SHL]), .ROR(op[O_ROR]), .ROL(op[O_ROL]), .NEG(op[O_NEG]),
    .NOT(op[O_NOT]),
    .R0in(en[0]),   .R1in(en[1]),   .R2in(en[2]),   .R3in(en[3]),
    .R4in(en[4]),   .R5in(en[5]),   .R6in(en[6]),   .R7in(en[7]),
    .R8in(en[8]),   .R9in(en[9]),   .R10in(en[10]), .R11in(en[11]),
    .R12in(en[12]), .R13in(en[13]), .R14in(en[14]), .R15in(en[15]),
    .HIin(en[E_HI]), .LOin(en[E_LO]), .PCin(en[E_PC]), .IRin(en[E_IR]),
    .Zin(en[E_Z]), .Yin(en[E_Y]), .MARin(en[E_MAR]), .MDRin(en[E_MDR]),
    .IN(in_w),
    .BusMuxOut(bus),
    .PC(pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    sel = '0; en = '0; op = '0; Read = 1'b0; IncPC = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // put one source on the bus and compare
  task automatic show(input int s, input logic [31:0] exp, input string tag);
    sel = '0;
    sel[s] = 1'b1;
    #1;
    check(tag, bus, exp);
    sel = '0;
  endtask

  task automatic xfer(input int s, input int d);
    idle();
    sel[s] = 1'b1;
    en[d]  = 1'b1;
    tick();
    idle();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    idle();
    in_w = v; Read = 1'b1; en[E_MDR] = 1'b1;
    tick();
    idle();
  endtask

  task automatic alu(input int s, input int o);
    idle();
    sel[s] = 1'b1; op[o] = 1'b1; en[E_Z] = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    idle();
    in_w  = 32'h0;
    reset = 1'b0;
    #12;
    check("reset_bus", bus, 32'h0);
    check("reset_pc",  pc,  32'h0);
    reset = 1'b1;
    tick();

    // MDR load path into R0, R7, R4
    load_mdr(32'h22);
    show(S_MDR, 32'h22, "mdr_22");
    xfer(S_MDR, 0);
    show(0, 32'h22, "r0_load");
    load_mdr(32'h24); xfer(S_MDR, 7);
    show(7, 32'h24, "r7_load");
    load_mdr(32'h28); xfer(S_MDR, 4);
    show(4, 32'h28, "r4_load");

    // instruction fetch
    idle();
    in_w = 32'h8A80_0000; Read = 1'b1; en[E_MDR] = 1'b1; en[E_PC] = 1'b1; IncPC = 1'b1;
    tick(); idle();
    check("fetch_pc", pc, 32'h1);
    show(S_MDR, 32'h8A80_0000, "fetch_mdr");
    xfer(S_MDR, E_IR);
    show(S_IR, 32'h8A80_0000, "fetch_ir");
    show(S_C, 32'h0, "c_zero");

    // immediate sign extension
    load_mdr(32'h0004_0001); xfer(S_MDR, E_IR);
    show(S_C, 32'hFFFC_0001, "c_neg");
    load_mdr(32'h7FF3_0005); xfer(S_MDR, E_IR);
    show(S_C, 32'h0003_0005, "c_pos");

    // NEG / NOT
    alu(0, O_NEG); xfer(S_ZL, 5);
    show(5, 32'hFFFF_FFDE, "neg_r5");
    show(0, 32'h22, "neg_r0_kept");
    show(S_ZH, 32'h0, "neg_zhi");
    alu(0, O_NOT);
    show(S_ZL, 32'hFFFF_FFDD, "not");

    // ADD / SUB / AND / OR with Y=0x24, B=0x28
    xfer(7, E_Y);
    show(S_Y, 32'h24, "y_load");
    alu(4, O_ADD); show(S_ZL, 32'h0000_004C, "add");
    alu(4, O_SUB); show(S_ZL, 32'hFFFF_FFFC, "sub");
    show(S_ZH, 32'h0, "sub_zhi");
    alu(4, O_AND); show(S_ZL, 32'h0000_0020, "and");
    alu(4, O_OR);  show(S_ZL, 32'h0000_002C, "or");
    // ADD precedes SUB in port order
    idle(); sel[4] = 1'b1; op[O_ADD] = 1'b1; op[O_SUB] = 1'b1; en[E_Z] = 1'b1;
    tick(); idle();
    show(S_ZL, 32'h0000_004C, "op_priority");

    // MUL / DIV with Y=-2, B=3
    load_mdr(32'hFFFF_FFFE); xfer(S_MDR, E_Y);
    load_mdr(32'h3);
    alu(S_MDR, O_MUL);
    show(S_ZH, 32'hFFFF_FFFF, "mul_hi");
    show(S_ZL, 32'hFFFF_FFFA, "mul_lo");
    alu(S_MDR, O_DIV);
    show(S_ZL, 32'h0, "div_q");
    show(S_ZH, 32'hFFFF_FFFE, "div_r");
    load_mdr(32'h0);
    alu(S_MDR, O_DIV);
    show(S_ZL, 32'h0, "div0_lo");
    show(S_ZH, 32'h0, "div0_hi");

    // shifts / rotates with Y=0xFFFFFFFE
    load_mdr(32'h1);
    alu(S_MDR, O_SHR);  show(S_ZL, 32'h7FFF_FFFF, "shr");
    alu(S_MDR, O_SHRA); show(S_ZL, 32'hFFFF_FFFF, "shra");
    load_mdr(32'h4);
    alu(S_MDR, O_SHL);  show(S_ZL, 32'hFFFF_FFE0, "shl");
    alu(S_MDR, O_ROR);  show(S_ZL, 32'hEFFF_FFFF, "ror");
    alu(S_MDR, O_ROL);  show(S_ZL, 32'hFFFF_FFEF, "rol");

    // 7 / -2 -> quotient -3, remainder 1
    load_mdr(32'h7); xfer(S_MDR, E_Y);
    load_mdr(32'hFFFF_FFFE);
    alu(S_MDR, O_DIV);
    show(S_ZL, 32'hFFFF_FFFD, "div_q2");
    show(S_ZH, 32'h0000_0001, "div_r2");

    // bus priority
    idle(); sel[0] = 1'b1; sel[5] = 1'b1; #1;
    check("prio_r0_r5", bus, 32'h22);
    idle(); in_w = 32'h5555_AAAA; sel[S_MDR] = 1'b1; sel[S_IN] = 1'b1; #1;
    check("prio_mdr_in", bus, 32'hFFFF_FFFE);
    idle(); sel[S_IN] = 1'b1; #1;
    check("in_bus", bus, 32'h5555_AAAA);

    // PC load from bus and source=destination in the same edge
    xfer(0, E_PC);
    check("pc_from_bus", pc, 32'h22);
    idle(); sel[S_PC] = 1'b1; en[E_PC] = 1'b1; IncPC = 1'b1; en[9] = 1'b1;
    tick(); idle();
    check("pc_inc", pc, 32'h23);
    show(9, 32'h22, "pre_edge_bus");
    xfer(S_PC, E_MAR);
    show(S_MAR, 32'h23, "mar_load");
    xfer(4, E_HI); xfer(7, E_LO);
    show(S_HI, 32'h28, "hi_load");
    show(S_LO, 32'h24, "lo_load");

    // asynchronous reset mid-stream with R5in held high
    idle();
    @(posedge clk);
    #2;
    en[5] = 1'b1;
    reset = 1'b0;
    #1;
    check("arst_pc", pc, 32'h0);
    sel[5] = 1'b1; #1;
    check("arst_r5", bus, 32'h0);
    sel = '0;
    sel[S_IN] = 1'b1;
    @(posedge clk); #1;
    sel = '0; sel[5] = 1'b1; #1;
    check("arst_r5_held", bus, 32'h0);
    idle();
    show(0, 32'h0, "arst_r0");
    show(S_ZH, 32'h0, "arst_zhi");
    show(S_MDR, 32'h0, "arst_mdr");
    show(S_Y, 32'h0, "arst_y");
    show(S_HI, 32'h0, "arst_hi");
    #2;
    reset = 1'b1;
    tick();
    check("post_bus", bus, 32'h0);
    check("post_pc", pc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
